// File: rtl/easy_fifo_axis_reader.sv
// Purpose : adapts a native FIFO read port (1-cycle read latency) to a full-throughput
//           AXI-Stream master through a 2-entry buffer (head + skid).
// Latency : fifo_rd_en in cycle 0 -> m_axis_tvalid in cycle 2.
// Backpressure: while m_axis_tready is low, tdata/tvalid hold. Reads stop once the
//               buffer plus the in-flight word would exceed two entries.
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   fifo_rd_en        : read strobe to FIFO (combinational)
//   fifo_rd_data      : FIFO data, valid the cycle after an accepted read
//   fifo_rd_empty     : FIFO empty flag
//   m_axis_tdata/tvalid/tready : AXI-Stream master
//   buf_level         : words currently held in the buffer (0..2)
module easy_fifo_axis_reader #(
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              fifo_rd_en,
   input  logic [DWIDTH-1:0] fifo_rd_data,
   input  logic              fifo_rd_empty,
   output logic [DWIDTH-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [1:0]        buf_level
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              inflight_q, inflight_d;
   logic              tvalid_q, tvalid_d;
   logic [DWIDTH-1:0] head_q, head_d;
   logic [DWIDTH-1:0] skid_q, skid_d;

   logic              pop;
   logic              capture;
   logic [2:0]        fill;

   assign buf_level     = state_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = head_q;

   assign pop     = tvalid_q & m_axis_tready;
   // A word read last cycle lands on fifo_rd_data now.
   assign capture = inflight_q;

   // Occupancy after this edge if no new read is issued; pop is only possible
   // with a non-empty buffer, so the subtraction never underflows.
   assign fill       = {1'b0, buf_level} + {2'b00, inflight_q} - {2'b00, pop};
   assign fifo_rd_en = ~fifo_rd_empty & rst_n & (fill < 3'd2);
   assign inflight_d = fifo_rd_en;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (capture) begin
               state_d = ONE;
               head_d  = fifo_rd_data;
            end
         end
         ONE: begin
            if (capture && !pop) begin
               state_d = TWO;
               skid_d  = fifo_rd_data;
            end else if (!capture && pop) begin
               state_d = EMPTY;
            end else if (capture && pop) begin
               // Head leaves and the arriving word replaces it at the same edge.
               head_d = fifo_rd_data;
            end
         end
         TWO: begin
            // No capture can arrive here: the read gate keeps fill below two.
            if (pop) begin
               state_d = ONE;
               head_d  = skid_q;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      tvalid_d = (state_d != EMPTY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         inflight_q <= 1'b0;
         tvalid_q   <= 1'b0;
         head_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         tvalid_q   <= tvalid_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
      end
   end

endmodule
